chorus_mod: RTL and testbench
=============================

CHORUS_MOD -- requirements
Module: chorus_mod

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed audio sample width.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning delay-buffer address width; DEPTH = 2^ADDR_W samples.
REQ-003 SHALL have parameter PHASE_W, default 16, meaning LFO phase accumulator width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clk_enable  input  1  global enable; low freezes all state.
REQ-007 SHALL have port sample_valid  input  1  single-cycle strobe qualifying din.
REQ-008 SHALL have port din  input  DATA_W  signed two's-complement input sample.
REQ-009 SHALL have port base_delay  input  ADDR_W+8  unsigned centre delay in samples, Q(ADDR_W).8.
REQ-010 SHALL have port mod_depth  input  ADDR_W+8  unsigned peak modulation in samples, Q(ADDR_W).8.
REQ-011 SHALL have port rate_inc  input  PHASE_W  LFO phase increment per accepted sample.
REQ-012 SHALL have ports dry_gain, wet_gain  input  16  unsigned Q1.15 gains; 0x8000 = 1.0.
REQ-013 SHALL have port bypass  input  1  output equals din when high.
REQ-014 SHALL have port ce_out  output  1  equal to clk_enable, combinational.
REQ-015 SHALL have port dout  output  DATA_W  signed mixed output, registered.
REQ-016 SHALL have port dout_valid  output  1  one-cycle pulse qualifying dout.
REQ-017 SHALL have port overrun  output  1  sticky flag: a sample was dropped.

Function
REQ-018 SHALL advance state only on clk edges with clk_enable high; with clk_enable low all registers, RAM writes and sample_valid acceptance are suspended.
REQ-019 SHALL sequence via FSM IDLE -> RD0 -> RD1 -> INTERP -> MIX -> IDLE, one state per enabled cycle; IDLE -> RD0 only on sample_valid.
REQ-020 SHALL on acceptance in IDLE write din to RAM[wr_ptr], latch din and all control inputs, compute tap addresses from the pre-increment wr_ptr, then increment wr_ptr modulo DEPTH (DEPTH-1 wraps to 0).
REQ-021 SHALL compute tri = phase[MSB] ? ~phase[PHASE_W-2:0] : phase[PHASE_W-2:0] and offset = (tri * mod_depth) >> (PHASE_W-1), truncating.
REQ-022 SHALL form d = base_delay + offset, clamped to [0x100, (DEPTH-2)<<8]; di = d[ADDR_W+7:8], f = d[7:0].
REQ-023 SHALL read tap A at (wr_ptr - di) mod DEPTH in RD0 and tap B at (wr_ptr - di - 1) mod DEPTH in RD1.
REQ-024 SHALL return 0 for any tap whose distance exceeds fill, where fill counts accepted samples since reset, saturating at DEPTH.
REQ-025 SHALL compute wet = A + (((B - A) * f) >>> 8), arithmetic shift, full-precision intermediate.
REQ-026 SHALL compute y = (din*dry_gain + wet*wet_gain + 2^14) >>> 15, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 SHALL drive dout = din (latched) instead of y when bypass was high at acceptance; RAM write, fill and LFO update still occur.
REQ-028 SHALL assert dout_valid for exactly one cycle, 5 enabled cycles after the accepting edge; dout holds until the next update.
REQ-029 SHALL advance phase by rate_inc (mod 2^PHASE_W) once per accepted sample, after the delay is computed.
REQ-030 SHALL drop sample_valid arriving in any non-IDLE state, leave RAM/pointers untouched, and set overrun until reset.

Reset
REQ-031 SHALL, while reset is high, force FSM=IDLE, wr_ptr=0, fill=0, phase=0, dout=0, dout_valid=0, overrun=0; RAM contents are not cleared (masked by REQ-024).
REQ-032 SHALL abandon any in-flight sample when reset asserts mid-sequence; no dout_valid is produced for it.

Verification (DATA_W=16, ADDR_W=6, samples spaced 8 cycles, clk_enable=1 unless stated)
REQ-033 SHALL cover reset mid-RD1 -> dout=0, dout_valid stays 0, overrun=0; next sample after release yields dout_valid 5 cycles later.
REQ-034 SHALL cover base_delay=0x0800, mod_depth=0, wet=0x8000, dry=0, impulse din=0x1000 then zeros -> dout=0x1000 exactly on the 9th output, 0 elsewhere.
REQ-035 SHALL cover base_delay=0x0880, ramp din=0,100,200,... -> after 10 samples dout = din - 850 each sample.
REQ-036 SHALL cover dry=wet=0x8000, constant din=0x7000 for 20 samples -> dout=0x7FFF after fill, 0x7000 before.
REQ-037 SHALL cover second sample_valid 2 cycles after first -> one dout_valid, overrun=1 thereafter; clk_enable low 3 cycles mid-sequence delays dout_valid by 3.
REQ-038 SHALL cover 200 samples, base_delay=0x0800, bypass toggled at sample 100 -> delayed-by-8 output across wr_ptr wrap, dout=din from sample 100.

Source files
------------

// File: rtl/chorus_mod.sv
`timescale 1ns/1ps
// chorus_mod: single-voice chorus. Each accepted sample is written to a
// circular delay line. An LFO-modulated fractional delay picks two
// neighbouring taps, which are linearly interpolated into a "wet" sample.
// The wet sample is mixed with the dry input and saturated to DATA_W bits.
module chorus_mod #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int PHASE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   din,
  input  logic [ADDR_W+7:0]   base_delay,
  input  logic [ADDR_W+7:0]   mod_depth,
  input  logic [PHASE_W-1:0]  rate_inc,
  input  logic [15:0]         dry_gain,
  input  logic [15:0]         wet_gain,
  input  logic                bypass,
  output logic                ce_out,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DW    = ADDR_W + 8;          // Q(ADDR_W).8 delay width
  localparam int PW    = PHASE_W - 1 + DW;    // triangle * depth product
  localparam int IW    = DATA_W + 10;         // interpolation intermediate
  localparam int ACC_W = DATA_W + 19;         // mixer accumulator

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD0    = 3'd1;
  localparam logic [2:0] S_RD1    = 3'd2;
  localparam logic [2:0] S_INTERP = 3'd3;
  localparam logic [2:0] S_MIX    = 3'd4;

  // Delay is kept at least one sample (tap A never reads the sample being
  // written) and at most DEPTH-2 (tap B stays inside the buffer).
  localparam logic [DW:0]       D_MIN    = (DW+1)'(256);
  localparam logic [DW:0]       D_MAX    = (DW+1)'((DEPTH - 2) * 256);
  localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1 << 14);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  // Control state
  logic [2:0]         state;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W:0]    fill;
  logic [PHASE_W-1:0] phase;
  logic               accept;

  // Delay computation at acceptance
  logic [PHASE_W-2:0] tri_val;
  logic [DW-1:0]      offset;
  logic [DW:0]        d_sum;
  logic [DW-1:0]      d_clamp;
  logic [ADDR_W-1:0]  d_int;
  logic [ADDR_W:0]    d_next;
  logic [ADDR_W-1:0]  tap_addr_a;
  logic               ok_a_now;
  logic               ok_b_now;

  // Per-sample latched context
  logic [DATA_W-1:0]  din_q;
  logic [15:0]        dry_q;
  logic [15:0]        wetg_q;
  logic               bypass_q;
  logic [ADDR_W-1:0]  addr_a_q;
  logic [ADDR_W-1:0]  addr_b_q;
  logic [7:0]         frac_q;
  logic               ok_a_q;
  logic               ok_b_q;

  // Delay line
  logic [DATA_W-1:0]  ram [DEPTH];
  logic [DATA_W-1:0]  ram_q;
  logic [ADDR_W-1:0]  rd_addr;

  // Datapath
  logic [DATA_W-1:0]        tap_a_q;
  logic [DATA_W-1:0]        tap_b;
  logic signed [DATA_W:0]   diff;
  logic signed [IW-1:0]     interp;
  logic signed [IW-1:0]     wet_full;
  logic signed [DATA_W:0]   wet_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        y;
  logic                     out_pend;

  assign ce_out  = clk_enable;
  assign accept  = clk_enable && sample_valid && (state == S_IDLE);
  assign rd_addr = (state == S_RD0) ? addr_a_q : addr_b_q;

  // Modulated, clamped delay and tap geometry for the sample being accepted.
  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    tri_val = phase[PHASE_W-1] ? ~phase[PHASE_W-2:0] : phase[PHASE_W-2:0];
    offset  = DW'(({{DW{1'b0}}, tri_val} * {{(PHASE_W-1){1'b0}}, mod_depth})
                  >> (PHASE_W-1));
    d_sum   = {1'b0, base_delay} + {1'b0, offset};
    if (d_sum < D_MIN)      d_clamp = D_MIN[DW-1:0];
    else if (d_sum > D_MAX) d_clamp = D_MAX[DW-1:0];
    else                    d_clamp = d_sum[DW-1:0];
    d_int      = d_clamp[DW-1:8];
    d_next     = {1'b0, d_int} + (ADDR_W+1)'(1);
    tap_addr_a = wr_ptr - d_int;
    // A tap further back than the number of samples written holds stale data.
    ok_a_now   = ({1'b0, d_int} <= fill);
    ok_b_now   = (d_next <= fill);
  end

  // Sequencer, write pointer, fill level, LFO phase and sticky overrun.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      fill    <= '0;
      phase   <= '0;
      overrun <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        S_IDLE:   if (sample_valid) state <= S_RD0;
        S_RD0:    state <= S_RD1;
        S_RD1:    state <= S_INTERP;
        S_INTERP: state <= S_MIX;
        default:  state <= S_IDLE;
      endcase
      if (accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (fill != FILL_MAX) fill <= fill + (ADDR_W+1)'(1);
        phase  <= phase + rate_inc;
      end
      if (sample_valid && (state != S_IDLE)) overrun <= 1'b1;
    end
  end

  // Hold the sample, gains and tap geometry for the rest of the sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_q    <= '0;
      dry_q    <= '0;
      wetg_q   <= '0;
      bypass_q <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      frac_q   <= '0;
      ok_a_q   <= 1'b0;
      ok_b_q   <= 1'b0;
    end else if (accept) begin
      din_q    <= din;
      dry_q    <= dry_gain;
      wetg_q   <= wet_gain;
      bypass_q <= bypass;
      addr_a_q <= tap_addr_a;
      addr_b_q <= tap_addr_a - ADDR_W'(1);
      frac_q   <= d_clamp[7:0];
      ok_a_q   <= ok_a_now;
      ok_b_q   <= ok_b_now;
    end
  end

  // Delay-line write on acceptance, synchronous tap read every enabled cycle.
  // NOTE: the RAM is deliberately not reset; stale words are masked by the
  // fill level, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      if (accept) ram[wr_ptr] <= din;
      ram_q <= ram[rd_addr];
    end
  end

  // Interpolation, dry/wet mix, rounding and saturation.
  always_comb begin
    tap_b    = ok_b_q ? ram_q : '0;
    diff     = $signed({tap_b[DATA_W-1], tap_b})
             - $signed({tap_a_q[DATA_W-1], tap_a_q});
    interp   = $signed({{9{diff[DATA_W]}}, diff})
             * $signed({{(DATA_W+2){1'b0}}, frac_q});
    wet_full = $signed({{10{tap_a_q[DATA_W-1]}}, tap_a_q}) + (interp >>> 8);
    acc      = $signed({{19{din_q[DATA_W-1]}}, din_q})
               * $signed({{(DATA_W+3){1'b0}}, dry_q})
             + $signed({{18{wet_q[DATA_W]}}, wet_q})
               * $signed({{(DATA_W+3){1'b0}}, wetg_q})
             + ROUND;
    shifted  = acc_q >>> 15;
    if (shifted > SAT_MAX)      y = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) y = SAT_MIN[DATA_W-1:0];
    else                        y = DATA_W'(shifted);
  end

  // One pipeline stage per state; the result is published one cycle after MIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_a_q    <= '0;
      wet_q      <= '0;
      acc_q      <= '0;
      out_pend   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (clk_enable) begin
      if (state == S_RD1)    tap_a_q <= ok_a_q ? ram_q : '0;
      if (state == S_INTERP) wet_q   <= (DATA_W+1)'(wet_full);
      if (state == S_MIX)    acc_q   <= acc;
      out_pend   <= (state == S_MIX);
      dout_valid <= out_pend;
      if (out_pend) dout <= bypass_q ? din_q : y;
    end
  end

endmodule

// File: tb/tb_chorus_mod.sv
`timescale 1ns/1ps
// tb_chorus_mod: directed scenarios for chorus_mod with DATA_W=16, ADDR_W=6.
// Samples are spaced 8 clocks apart; outputs are sampled 1 ns after rising edges.
module tb_chorus_mod;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 6;
  localparam int PHASE_W = 16;

  logic                clk;
  logic                reset;
  logic                clk_enable;
  logic                sample_valid;
  logic [DATA_W-1:0]   din;
  logic [ADDR_W+7:0]   base_delay;
  logic [ADDR_W+7:0]   mod_depth;
  logic [PHASE_W-1:0]  rate_inc;
  logic [15:0]         dry_gain;
  logic [15:0]         wet_gain;
  logic                bypass;
  logic                ce_out;
  logic [DATA_W-1:0]   dout;
  logic                dout_valid;
  logic                overrun;

  int checks = 0;
  int errors = 0;

  chorus_mod #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .PHASE_W (PHASE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .sample_valid (sample_valid),
    .din          (din),
    .base_delay   (base_delay),
    .mod_depth    (mod_depth),
    .rate_inc     (rate_inc),
    .dry_gain     (dry_gain),
    .wet_gain     (wet_gain),
    .bypass       (bypass),
    .ce_out       (ce_out),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reset for two edges; returns 1 ns after a rising edge.
  task automatic do_reset();
    reset        = 1'b1;
    clk_enable   = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Present one sample and observe the following 7 edges (8-cycle spacing).
  task automatic do_sample(input logic [15:0] x, output logic [15:0] got,
                           output int lat, output int pulses);
    din = x;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    lat = -1;
    pulses = 0;
    got = 16'hxxxx;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (dout_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          got = dout;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    int lat, pulses, seen;
    @(posedge clk);
    #1;
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL rst_dout got=%h want=0000", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b want=0", overrun); end
    clk_enable = 1'b0;
    #1;
    checks++; if (ce_out !== 1'b0) begin errors++; $display("FAIL ce_out_low got=%b want=0", ce_out); end
    clk_enable = 1'b1;
    #1;
    checks++; if (ce_out !== 1'b1) begin errors++; $display("FAIL ce_out_high got=%b want=1", ce_out); end
    reset = 1'b0;
    bypass = 1'b1;
    // Accept a sample, then assert reset while the FSM sits in RD1.
    din = 16'h1234;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL midrst_dout got=%h want=0000", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got=%b want=0", overrun); end
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (dout_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abandoned_valid got=%0d pulses want=0", seen); end
    do_sample(16'h0555, got, lat, pulses);
    checks++; if (lat != 5 || pulses != 1) begin errors++; $display("FAIL post_rst_latency got=%0d/%0d want=5/1", lat, pulses); end
    checks++; if (got !== 16'h0555) begin errors++; $display("FAIL post_rst_dout got=%h want=0555", got); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL post_rst_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_impulse();
    logic [15:0] got, exp;
    int lat, pulses;
    do_reset();
    base_delay = 14'h0800; mod_depth = '0; rate_inc = 16'h1234;
    dry_gain = 16'h0000; wet_gain = 16'h8000; bypass = 1'b0;
    for (int n = 0; n < 16; n++) begin
      do_sample((n == 0) ? 16'h1000 : 16'h0000, got, lat, pulses);
      exp = (n == 8) ? 16'h1000 : 16'h0000;
      checks++; if (lat != 5 || pulses != 1) begin errors++; $display("FAIL impulse_latency n=%0d got=%0d/%0d want=5/1", n, lat, pulses); end
      checks++; if (got !== exp) begin errors++; $display("FAIL impulse n=%0d got=%h want=%h", n, got, exp); end
    end
  endtask

  task automatic test_ramp_interp();
    logic [15:0] got, exp;
    int lat, pulses;
    do_reset();
    base_delay = 14'h0880; mod_depth = '0; rate_inc = 16'h0000;
    dry_gain = 16'h0000; wet_gain = 16'h8000; bypass = 1'b0;
    for (int n = 0; n < 20; n++) begin
      do_sample(16'(100 * n), got, lat, pulses);
      // n=8: tap B is one sample beyond the fill level and reads as zero.
      exp = (n == 8) ? 16'h0000 : 16'(100 * n - 850);
      if (n >= 8) begin
        checks++; if (got !== exp) begin errors++; $display("FAIL ramp_interp n=%0d got=%0d want=%0d", n, $signed(got), $signed(exp)); end
      end
    end
  endtask

  task automatic test_lfo();
    logic [15:0] got, exp;
    int lat, pulses;
    int delta [4];
    // Phase steps by a quarter turn: offsets 0x000, 0x100, 0x1FF, 0x0FF
    // on top of a 4.0 sample centre delay.
    delta[0] = 400; delta[1] = 500; delta[2] = 600; delta[3] = 500;
    do_reset();
    base_delay = 14'h0400; mod_depth = 14'h0200; rate_inc = 16'h4000;
    dry_gain = 16'h0000; wet_gain = 16'h8000; bypass = 1'b0;
    for (int n = 0; n < 16; n++) begin
      do_sample(16'(100 * n), got, lat, pulses);
      exp = 16'(100 * n - delta[n % 4]);
      if (n >= 8) begin
        checks++; if (got !== exp) begin errors++; $display("FAIL lfo n=%0d got=%0d want=%0d", n, $signed(got), $signed(exp)); end
      end
    end
  endtask

  task automatic test_clamp();
    logic [15:0] got, exp;
    int lat, pulses;
    do_reset();
    mod_depth = '0; rate_inc = 16'h0000;
    dry_gain = 16'h0000; wet_gain = 16'h8000; bypass = 1'b0;
    for (int n = 0; n < 70; n++) begin
      // Zero delay clamps to one sample; 0x3FFF clamps to DEPTH-2 = 62.
      base_delay = (n < 66) ? 14'h0000 : 14'h3FFF;
      do_sample(16'(100 * n), got, lat, pulses);
      if (n < 66) exp = (n == 0) ? 16'h0000 : 16'(100 * n - 100);
      else        exp = 16'(100 * (n - 62));
      if (n < 3 || n > 63) begin
        checks++; if (got !== exp) begin errors++; $display("FAIL clamp n=%0d got=%0d want=%0d", n, $signed(got), $signed(exp)); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] got, exp;
    int lat, pulses;
    do_reset();
    base_delay = 14'h0800; mod_depth = '0; rate_inc = 16'h0100;
    dry_gain = 16'h8000; wet_gain = 16'h8000; bypass = 1'b0;
    for (int n = 0; n < 32; n++) begin
      do_sample((n < 20) ? 16'h7000 : 16'h9000, got, lat, pulses);
      if (n < 8)       exp = 16'h7000;
      else if (n < 20) exp = 16'h7FFF;
      else if (n < 28) exp = 16'h0000;
      else             exp = 16'h8000;
      checks++; if (got !== exp) begin errors++; $display("FAIL saturation n=%0d got=%h want=%h", n, got, exp); end
    end
  endtask

  task automatic test_overrun_enable();
    logic [15:0] got;
    int lat, pulses;
    do_reset();
    bypass = 1'b1;
    din = 16'h0ABC;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    din = 16'h0DEF;
    @(posedge clk);
    #1 sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    lat = -1; pulses = 0; got = 16'hxxxx;
    for (int c = 3; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (dout_valid) begin
        pulses++;
        if (lat < 0) begin lat = c; got = dout; end
      end
    end
    checks++; if (pulses != 1 || lat != 5) begin errors++; $display("FAIL overrun_pulses got=%0d@%0d want=1@5", pulses, lat); end
    checks++; if (got !== 16'h0ABC) begin errors++; $display("FAIL overrun_dout got=%h want=0abc", got); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b want=1", overrun); end
    // Freeze for three edges while the sample is in RD1.
    din = 16'h0321;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    lat = -1; pulses = 0; got = 16'hxxxx;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (dout_valid) begin
        pulses++;
        if (lat < 0) begin lat = c; got = dout; end
      end
      if (c == 2) begin
        checks++; if (ce_out !== 1'b0) begin errors++; $display("FAIL ce_out_frozen got=%b want=0", ce_out); end
      end
      if (c == 1) clk_enable = 1'b0;
      if (c == 4) clk_enable = 1'b1;
    end
    checks++; if (pulses != 1 || lat != 8) begin errors++; $display("FAIL enable_latency got=%0d@%0d want=1@8", pulses, lat); end
    checks++; if (got !== 16'h0321) begin errors++; $display("FAIL enable_dout got=%h want=0321", got); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
    do_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b want=0", overrun); end
  endtask

  task automatic test_wrap();
    logic [15:0] got, exp;
    logic [15:0] hist [200];
    int lat, pulses;
    do_reset();
    base_delay = 14'h0800; mod_depth = '0; rate_inc = 16'h0777;
    dry_gain = 16'h0000; wet_gain = 16'h8000;
    for (int n = 0; n < 200; n++) begin
      hist[n] = 16'(n * 301 - 30000);
      bypass = (n >= 100);
      do_sample(hist[n], got, lat, pulses);
      if (n >= 100)   exp = hist[n];
      else if (n < 8) exp = 16'h0000;
      else            exp = hist[n-8];
      checks++; if (lat != 5 || pulses != 1) begin errors++; $display("FAIL wrap_latency n=%0d got=%0d/%0d want=5/1", n, lat, pulses); end
      checks++; if (got !== exp) begin errors++; $display("FAIL wrap n=%0d got=%h want=%h", n, got, exp); end
    end
  endtask

  initial begin
    reset        = 1'b1;
    clk_enable   = 1'b1;
    sample_valid = 1'b0;
    din          = '0;
    base_delay   = '0;
    mod_depth    = '0;
    rate_inc     = '0;
    dry_gain     = '0;
    wet_gain     = '0;
    bypass       = 1'b0;
    test_reset();
    test_impulse();
    test_ramp_interp();
    test_lfo();
    test_clamp();
    test_saturation();
    test_overrun_enable();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
